// File: rtl/branch_pc_unit.sv
// PC ownership and branch resolution downstream of the ALU: registered flags,
// conditional/unconditional branches, single-bubble flush, link write and halt.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        halt,
  input  logic        flag_we,
  input  logic [2:0]  alu_flags,
  input  logic [2:0]  br_type,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic [2:0]  flags_q,
  output logic        taken,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;
  typedef enum logic [2:0] {
    BR_NONE = 3'b000, BR_BR = 3'b001, BR_BLTZ = 3'b010, BR_BZ = 3'b011,
    BR_BNZ  = 3'b100, BR_BCY = 3'b101, BR_BNCY = 3'b110, BR_BL = 3'b111
  } br_e;

  state_e      state, state_nx;
  logic        accept;
  logic        cond;
  logic        do_branch;
  logic        do_link;
  logic [31:0] pc_seq;
  logic [31:0] target_aligned;

  assign accept         = (state == RUN) && instr_valid && !stall;
  assign pc_seq         = pc + PC_STEP;
  assign target_aligned = br_target & ~32'h3;
  assign flush          = (state == FLUSH);
  assign halted         = (state == HALT);

  // Conditions use the registered flags, so a same-cycle flag_we is not visible here.
  always_comb begin
    cond = 1'b0;
    case (br_e'(br_type))
      BR_BR,
      BR_BL:   cond = 1'b1;
      BR_BLTZ: cond = flags_q[1];
      BR_BZ:   cond = flags_q[0];
      BR_BNZ:  cond = !flags_q[0];
      BR_BCY:  cond = flags_q[2];
      BR_BNCY: cond = !flags_q[2];
      default: cond = 1'b0;
    endcase
  end

  assign do_branch = accept && !halt && cond;
  assign do_link   = accept && !halt && (br_e'(br_type) == BR_BL);

  always_comb begin
    state_nx = state;
    case (state)
      RUN: begin
        if (accept && halt)   state_nx = HALT;
        else if (do_branch)   state_nx = FLUSH;
      end
      FLUSH:   if (!stall) state_nx = RUN;
      HALT:    state_nx = HALT;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      flags_q   <= '0;
      taken     <= 1'b0;
      link_we   <= 1'b0;
      link_addr <= '0;
    end else begin
      state   <= state_nx;
      taken   <= do_branch;
      link_we <= do_link;
      if (accept && !halt) begin
        pc <= do_branch ? target_aligned : pc_seq;
        if (flag_we) flags_q <= alu_flags;
      end
      if (do_link) link_addr <= pc_seq;
    end
  end

endmodule
